clas_flag_stage: RTL and testbench

CLAS_FLAG_STAGE -- requirements
Module: clas_flag_stage

---
 rtl/clas_flag_stage.sv | 136 +++++++++++++
 tb/tb_clas_flag_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/clas_flag_stage.sv
// Flag-computation stage for an 8-bit add/sub unit: computes C/Z/N/V at acceptance,
// buffers results in a 2-entry FIFO and keeps saturating operation/overflow counters.
module clas_flag_stage #(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_sel,
  input  logic [7:0] in_result,
  input  logic       in_c_out,
  input  logic       in_a_msb,
  input  logic       in_b_msb,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_result,
  output logic       out_sel,
  output logic       out_c,
  output logic       out_z,
  output logic       out_n,
  output logic       out_v,
  output logic [7:0] op_count,
  output logic [7:0] ovf_count
);

  localparam logic [1:0] Full = 2'(DEPTH);

  logic [7:0] res_q [DEPTH];
  logic       sel_q [DEPTH];
  logic       c_q   [DEPTH];
  logic       z_q   [DEPTH];
  logic       n_q   [DEPTH];
  logic       v_q   [DEPTH];

  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] occ_q, occ_d;
  logic [7:0] op_cnt_q, op_cnt_d;
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  logic push, pop;
  logic flag_c, flag_z, flag_n, flag_v;

  // Handshake signals depend on registered occupancy only.
  assign in_ready  = (occ_q < Full);
  assign out_valid = (occ_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    flag_c = in_c_out;
    flag_z = (in_result == 8'h00);
    flag_n = in_result[7];
    // Subtract overflows when operand signs differ; add when they match.
    if (in_sel) begin
      flag_v = (in_a_msb != in_b_msb) && (in_result[7] != in_a_msb);
    end else begin
      flag_v = (in_a_msb == in_b_msb) && (in_result[7] != in_a_msb);
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    op_cnt_d  = op_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
      if (op_cnt_q != 8'hFF) begin
        op_cnt_d = op_cnt_q + 8'd1;
      end
      if (flag_v && (ovf_cnt_q != 8'hFF)) begin
        ovf_cnt_d = ovf_cnt_q + 8'd1;
      end
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
      op_cnt_q  <= 8'h00;
      ovf_cnt_q <= 8'h00;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      op_cnt_q  <= op_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by occupancy.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      res_q[wr_ptr_q] <= in_result;
      sel_q[wr_ptr_q] <= in_sel;
      c_q[wr_ptr_q]   <= flag_c;
      z_q[wr_ptr_q]   <= flag_z;
      n_q[wr_ptr_q]   <= flag_n;
      v_q[wr_ptr_q]   <= flag_v;
    end
  end

  always_comb begin
    out_result = 8'h00;
    out_sel    = 1'b0;
    out_c      = 1'b0;
    out_z      = 1'b0;
    out_n      = 1'b0;
    out_v      = 1'b0;
    if (out_valid) begin
      out_result = res_q[rd_ptr_q];
      out_sel    = sel_q[rd_ptr_q];
      out_c      = c_q[rd_ptr_q];
      out_z      = z_q[rd_ptr_q];
      out_n      = n_q[rd_ptr_q];
      out_v      = v_q[rd_ptr_q];
    end
  end

  assign op_count  = op_cnt_q;
  assign ovf_count = ovf_cnt_q;

endmodule

// File: tb/tb_clas_flag_stage.sv
// Directed self-checking bench for clas_flag_stage.
module tb_clas_flag_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_sel;
  logic [7:0] in_result;
  logic       in_c_out;
  logic       in_a_msb;
  logic       in_b_msb;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_sel, out_c, out_z, out_n, out_v;
  logic [7:0] op_count;
  logic [7:0] ovf_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clas_flag_stage #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_result (in_result),
    .in_c_out  (in_c_out),
    .in_a_msb  (in_a_msb),
    .in_b_msb  (in_b_msb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_sel   (out_sel),
    .out_c     (out_c),
    .out_z     (out_z),
    .out_n     (out_n),
    .out_v     (out_v),
    .op_count  (op_count),
    .ovf_count (ovf_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic sel, input logic [7:0] r, input logic c,
                       input logic a, input logic b);
    in_valid  = v;
    in_sel    = sel;
    in_result = r;
    in_c_out  = c;
    in_a_msb  = a;
    in_b_msb  = b;
  endtask

  task automatic check_flags(input string tag, input logic [7:0] r, input logic sel,
                             input logic c, input logic z, input logic n, input logic v);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_result"}, 32'(out_result), 32'(r));
    check({tag, "_sel"}, 32'(out_sel), 32'(sel));
    check({tag, "_c"}, 32'(out_c), 32'(c));
    check({tag, "_z"}, 32'(out_z), 32'(z));
    check({tag, "_n"}, 32'(out_n), 32'(n));
    check({tag, "_v"}, 32'(out_v), 32'(v));
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_outs"}, {23'd0, out_result, out_sel, out_c, out_z, out_n, out_v}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    check_empty("reset");
    check("reset_op", 32'(op_count), 32'd0);
    check("reset_ovf", 32'(ovf_count), 32'd0);

    // Add overflow: 0x80 from two positive operands.
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_flags("add_ovf", 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("add_ovf_cnt", 32'(ovf_count), 32'd1);
    check("add_op_cnt", 32'(op_count), 32'd1);
    tick();
    check_empty("add_drained");

    // Subtract to zero, no borrow.
    drive(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_flags("sub_zero", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("sub_zero_ovf_cnt", 32'(ovf_count), 32'd1);
    tick();
    check_empty("sub_drained");

    // Backpressure: fill, hold off third, then drain in order.
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0);
    tick();
    check("bp_ready1", 32'(in_ready), 32'd1);
    drive(1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0);
    tick();
    check("bp_ready2", 32'(in_ready), 32'd0);
    drive(1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
    tick();
    check("bp_head_held", 32'(out_result), 32'h11);
    check("bp_op_cnt", 32'(op_count), 32'd4);
    tick();
    check("bp_head_held2", 32'(out_result), 32'h11);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    check("bp_drain0", 32'(out_result), 32'h11);
    tick();
    check("bp_drain1", 32'(out_result), 32'h22);
    check("bp_drain1_valid", 32'(out_valid), 32'd1);
    tick();
    check_empty("bp_drained");
    check("bp_op_cnt_final", 32'(op_count), 32'd4);

    // Simultaneous push/pop at occupancy 1; 0x44 is a subtract overflow.
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h55, 1'b1, 1'b1, 1'b1);
    tick();
    check_flags("pp_first", 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    check_flags("pp_head", 8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("pp_ready", 32'(in_ready), 32'd1);
    check("pp_ovf_cnt", 32'(ovf_count), 32'd3);
    check("pp_op_cnt", 32'(op_count), 32'd6);
    tick();
    check("pp_hold", 32'(out_result), 32'h44);
    out_ready = 1'b1;
    tick();
    check_empty("pp_drained");

    // Reset with two entries buffered, with push and pop requested alongside.
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h66, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0);
    tick();
    check("rst_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 8'h88, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_empty("rst_mid");
    check("rst_mid_op", 32'(op_count), 32'd0);
    check("rst_mid_ovf", 32'(ovf_count), 32'd0);
    tick();
    check_empty("rst_mid_after");

    // Continuous stream with out_ready high: one accept per cycle, all overflowing.
    drive(1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 254; i++) tick();
    check("sat_op_254", 32'(op_count), 32'd254);
    check("sat_ovf_254", 32'(ovf_count), 32'd254);
    tick();
    check("sat_op_255", 32'(op_count), 32'd255);
    for (int i = 0; i < 5; i++) tick();
    check("sat_op_260", 32'(op_count), 32'hFF);
    check("sat_ovf_260", 32'(ovf_count), 32'hFF);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    check_empty("sat_drained");
    check("sat_op_hold", 32'(op_count), 32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
